// File: rtl/arith_pkg.sv
// arith_pkg: opcode and FSM state encodings shared by the arithmetic unit
package arith_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per cycle
module seq_divider #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quot,
  output logic [DATA_WIDTH-1:0] o_rem
);
  localparam int W = DATA_WIDTH;
  logic [W-1:0] r_quo, r_rem, r_div;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic r_busy;
  logic [W:0] w_sh;
  logic [W-1:0] w_sub;
  logic w_ge;
  // the dividend shifts out of r_quo while quotient bits shift in
  assign w_sh   = {r_rem, r_quo[W-1]};
  assign w_ge   = w_sh[W] | (w_sh[W-1:0] >= r_div);
  assign w_sub  = w_sh[W-1:0] - r_div;
  assign o_quot = {r_quo[W-2:0], w_ge};
  assign o_rem  = w_ge ? w_sub : w_sh[W-1:0];
  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == '0);
  // load on start, then one restoring step per cycle until the counter hits zero
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= CNT_WIDTH'(W - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_quo  <= o_quot;
      r_rem  <= o_rem;
      r_cnt  <= r_cnt - CNT_WIDTH'(1);
      r_busy <= (r_cnt != '0);
    end
endmodule

// File: rtl/arith_unit_seq.sv
// arith_unit_seq: handshaked add/sub/mul/div unit; define ARITH_OVF_EN for the Overflow output
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  input  logic [1:0]              ALU_FUN,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  output logic [2*DATA_WIDTH-1:0] Arith_OUT,
  output logic                    Carry_OUT,
  output logic                    Div_Zero,
  output logic                    Out_Valid,
  input  logic                    Out_Ready
`ifdef ARITH_OVF_EN
  ,
  output logic                    Overflow
`endif
);
  localparam int W = DATA_WIDTH;
  logic [1:0] r_state;
  logic [W:0] w_sum, w_dif;
  logic [2*W-1:0] w_prod, w_res;
  logic [W-1:0] w_quot, w_rem;
  logic w_carry, w_dz, w_accept, w_start, w_dv_busy, w_dv_done;
  assign w_sum    = {1'b0, A} + {1'b0, B};
  assign w_dif    = {1'b0, A} - {1'b0, B};
  assign w_prod   = {{W{1'b0}}, A} * {{W{1'b0}}, B};
  assign w_res    = (ALU_FUN == OP_ADD) ? {{(W-1){1'b0}}, w_sum} :
                    (ALU_FUN == OP_SUB) ? {{W{1'b0}}, w_dif[W-1:0]} :
                    (ALU_FUN == OP_MUL) ? w_prod : {A, {W{1'b1}}};
  assign w_carry  = (ALU_FUN == OP_ADD) ? w_sum[W] : (ALU_FUN == OP_SUB) ? w_dif[W] : 1'b0;
  assign w_dz     = (ALU_FUN == OP_DIV) && (B == '0);
  assign In_Ready = (r_state == ST_IDLE) && !w_dv_busy;
  assign Out_Valid = (r_state == ST_DONE);
  assign w_accept = In_Valid && In_Ready;
  assign w_start  = w_accept && (ALU_FUN == OP_DIV) && (B != '0);
`ifdef ARITH_OVF_EN
  logic w_ovf;
  assign w_ovf = (ALU_FUN == OP_ADD) ? (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]) :
                 (ALU_FUN == OP_SUB) ? (A[W-1] != B[W-1]) && (w_dif[W-1] != A[W-1]) : 1'b0;
`endif
  seq_divider #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_div (
    .CLK(CLK), .RST(RST), .i_start(w_start), .i_dividend(A), .i_divisor(B),
    .o_busy(w_dv_busy), .o_done(w_dv_done), .o_quot(w_quot), .o_rem(w_rem)
  );
  // sequence accept -> (divide) -> hold result until the consumer takes it
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_state   <= ST_IDLE;
      Arith_OUT <= '0;
      Carry_OUT <= 1'b0;
      Div_Zero  <= 1'b0;
`ifdef ARITH_OVF_EN
      Overflow  <= 1'b0;
`endif
    end else if (w_accept) begin
      Arith_OUT <= w_res;
      Carry_OUT <= w_carry;
      Div_Zero  <= w_dz;
`ifdef ARITH_OVF_EN
      Overflow  <= w_ovf;
`endif
      r_state   <= w_start ? ST_DIV : ST_DONE;
    end else if (r_state == ST_DIV && w_dv_done) begin
      Arith_OUT <= {w_rem, w_quot};
      r_state   <= ST_DONE;
    end else if (r_state == ST_DONE && Out_Ready) begin
      r_state   <= ST_IDLE;
    end
endmodule

// File: tb/tb_arith_unit_seq.sv
// tb_arith_unit_seq: scoreboard bench for arith_unit_seq with directed vectors
module tb_arith_unit_seq;
  localparam int W = 16;
  logic CLK = 1'b0, RST = 1'b1;
  logic [W-1:0] A = '0, B = '0;
  logic [1:0] ALU_FUN = 2'b00;
  logic In_Valid = 1'b0, Out_Ready = 1'b1;
  logic In_Ready, Carry_OUT, Div_Zero, Out_Valid;
  logic [2*W-1:0] Arith_OUT;
`ifdef ARITH_OVF_EN
  logic Overflow;
`endif
  typedef struct packed {
    logic [2*W-1:0] res;
    logic c;
    logic dz;
    logic ov;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, cyc = 0;

  arith_unit_seq #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Div_Zero(Div_Zero),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
`ifdef ARITH_OVF_EN
    , .Overflow(Overflow)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST && Out_Valid && Out_Ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %h expected none", Arith_OUT);
      end else begin
        e = sb.pop_front();
`ifdef ARITH_OVF_EN
        chk("result", {Arith_OUT, Carry_OUT, Div_Zero, Overflow}, {e.res, e.c, e.dz, e.ov});
`else
        chk("result", {Arith_OUT, Carry_OUT, Div_Zero}, {e.res, e.c, e.dz});
`endif
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic [2*W-1:0] res, input logic c, input logic dz, input logic ov,
                       output int acc);
    int n = 0;
    @(negedge CLK);
    while (!In_Ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!In_Ready) chk("accept_timeout", 64'(In_Ready), 64'd1);
    A = a;
    B = b;
    ALU_FUN = op;
    In_Valid = 1'b1;
    sb.push_back('{res, c, dz, ov});
    @(posedge CLK);
    #1 acc = cyc;
  endtask

  task automatic drop_inputs();
    In_Valid = 1'b0;
    A = '1;
    B = '1;
    ALU_FUN = 2'b01;
  endtask

  task automatic wait_valid(output int n, output int low);
    n = 0;
    low = 0;
    do begin
      @(negedge CLK);
      n++;
      if (!In_Ready) low++;
    end while (!Out_Valid && n < 200);
  endtask

  initial begin
    int acc, n, low;
    int accs[4];
    #2 RST = 1'b0;
    #1 chk("reset_state", {Arith_OUT, Carry_OUT, Div_Zero, Out_Valid, In_Ready}, {32'h0, 4'b0001});
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    issue(16'hFFFF, 16'h0001, 2'b00, 32'h0001_0000, 1'b1, 1'b0, 1'b0, acc);
    drop_inputs();
    wait_valid(n, low);
    chk("add_latency", 64'(n), 64'd1);

    issue(16'h0003, 16'h0005, 2'b01, 32'h0000_FFFE, 1'b1, 1'b0, 1'b0, acc);
    drop_inputs();
`ifdef ARITH_OVF_EN
    issue(16'h7FFF, 16'h0001, 2'b00, 32'h0000_8000, 1'b0, 1'b0, 1'b1, acc);
    drop_inputs();
`endif

    @(posedge CLK);
    #1 Out_Ready = 1'b0;
    issue(16'hFFFF, 16'hFFFF, 2'b10, 32'hFFFE_0001, 1'b0, 1'b0, 1'b0, acc);
    drop_inputs();
    wait_valid(n, low);
    chk("mul_latency", 64'(n), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("mul_hold", {Arith_OUT, Carry_OUT, Out_Valid, In_Ready}, {32'hFFFE_0001, 3'b010});
    end
    @(posedge CLK);
    #1 Out_Ready = 1'b1;

    issue(16'd100, 16'd7, 2'b11, {16'd2, 16'd14}, 1'b0, 1'b0, 1'b0, acc);
    drop_inputs();
    wait_valid(n, low);
    chk("div_latency", 64'(n), 64'd17);
    chk("div_inready_low", 64'(low), 64'd17);

    issue(16'h1234, 16'h0000, 2'b11, 32'h1234_FFFF, 1'b0, 1'b1, 1'b0, acc);
    drop_inputs();
    wait_valid(n, low);
    chk("divzero_latency", 64'(n), 64'd1);

    issue(16'd100, 16'd7, 2'b11, {16'd2, 16'd14}, 1'b0, 1'b0, 1'b0, acc);
    drop_inputs();
    repeat (8) @(posedge CLK);
    #1 RST = 1'b0;
    sb.delete();
    #1 chk("reset_mid_div", {Arith_OUT, Carry_OUT, Div_Zero, Out_Valid, In_Ready}, {32'h0, 4'b0001});
    @(negedge CLK);
    RST = 1'b1;
    issue(16'd2, 16'd3, 2'b00, 32'd5, 1'b0, 1'b0, 1'b0, acc);
    drop_inputs();
    wait_valid(n, low);
    chk("add_after_reset_latency", 64'(n), 64'd1);

    issue(16'd10, 16'd20, 2'b00, 32'd30, 1'b0, 1'b0, 1'b0, accs[0]);
    issue(16'h0010, 16'h0001, 2'b01, 32'h0000_000F, 1'b0, 1'b0, 1'b0, accs[1]);
    issue(16'h0100, 16'h0100, 2'b10, 32'h0001_0000, 1'b0, 1'b0, 1'b0, accs[2]);
    issue(16'h8000, 16'h8000, 2'b00, 32'h0001_0000, 1'b1, 1'b0, 1'b1, accs[3]);
    drop_inputs();
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(accs[i] - accs[i-1]), 64'd2);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
